regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the register file's single write port (write_enable3/write_reg_addr3/write_data3)
//  between NUM_REQ writeback sources, e.g. ALU result and load data.
//  Uses round-robin arbitration and one registered output stage.
//  Writes to r15 are steered to a separate PC-write strobe, because the register file has no r15 entry.
//  Exposes the in-flight write for forwarding/hazard checks.
//  Sits between the writeback sources and RegisterFile.
// PARAMETERS
//  NUM_REQ     2   number of writeback requesters (2..4)
//  DATA_W     32   write data width
//  ADDR_W      4   register address width
// PORTS
//  clk              in   1                  clock, all state on posedge
//  reset            in   1                  synchronous, active-low (0 = reset)
//  req_valid        in   NUM_REQ            requester i has a write pending
//  req_addr         in   NUM_REQ*ADDR_W     dest reg of requester i, slice [i*ADDR_W +: ADDR_W]
//  req_data         in   NUM_REQ*DATA_W     write data of requester i, slice [i*DATA_W +: DATA_W]
//  req_ready        out  NUM_REQ            requester i's write is accepted this cycle
//  stall            in   1                  hold the output stage (suppress commit)
//  write_enable3    out  1                  register file write strobe
//  write_reg_addr3  out  ADDR_W             register file write address
//  write_data3      out  DATA_W             register file write data
//  pc_write_enable  out  1                  write to r15 committing this cycle
//  pc_write_data    out  DATA_W             r15 write value
//  fwd_addr         in   ADDR_W             register being read by the consumer
//  fwd_hit          out  1                  output stage holds an uncommitted write to fwd_addr
//  fwd_data         out  DATA_W             data of that write (0 when !fwd_hit)
// BEHAVIOUR
//  - State: out_valid, out_addr, out_data (the output stage) and rr_ptr in [0, NUM_REQ-1].
//  - Reset (reset==0 at posedge):
//      out_valid=0, out_addr=0, out_data=0, rr_ptr=0.
//      Hence all outputs are 0, including write_enable3, pc_write_enable, fwd_hit and req_ready.
//  - can_load = !out_valid || !stall.
//      A stalled full stage accepts nothing. An empty stage loads even under stall.
//  - Grant selection:
//      Scan i = rr_ptr, rr_ptr+1, ... (mod NUM_REQ) and pick the first i with req_valid[i].
//      req_ready = onehot(grant) & {NUM_REQ{can_load}}; at most one bit is set.
//      req_ready is combinational from req_valid; requesters must not make valid depend on ready.
//  - Transfer (req_valid[i] & req_ready[i]):
//      At the posedge: out_valid=1, out_addr=req_addr[i], out_data=req_data[i], rr_ptr=(i+1)%NUM_REQ.
//      If no transfer and !stall, out_valid=0. With stall, the stage holds its contents.
//  - Commit (combinational):
//      commit = out_valid & !stall.
//      write_enable3 = commit & (out_addr != 4'hF).
//      pc_write_enable = commit & (out_addr == 4'hF).
//      write_reg_addr3/write_data3/pc_write_data always mirror out_addr/out_data.
//  - Latency: accepted on cycle N, committed on cycle N+1 at the earliest; 1 write/cycle sustained.
//  - Forwarding: fwd_hit = out_valid & (out_addr == fwd_addr), held through stall.
//  - Boundaries:
//      - Same address from two requesters in one cycle: the rr winner goes first; the loser lands next cycle.
//        Program order across sources is the sources' responsibility.
//      - rr_ptr wraps from NUM_REQ-1 to 0.
//      - An idle cycle leaves rr_ptr unchanged.
//      - Reset while out_valid=1: the pending write is discarded, with no write strobe that cycle.
//      - stall=1 with out_valid=0: no strobe, and a transfer is still allowed.
// STRUCTURE
//  - Shared package regfile_pkg:
//      REG_PC = 4'hF, DATA_W, ADDR_W;
//      typedef struct packed {logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data;} wb_req_t.
//  - Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs grant onehot and grant_idx.
//    It is purely combinational and is reused later by other shared resources.
//  - Top level: rr_arbiter, output-stage flops, commit decode and forwarding compare.
// TESTING
//  1. Reset: hold reset=0 2 cycles with all req_valid=1.
//     -> All outputs 0. Release, and the first grant is req0 (rr_ptr=0).
//  2. Both valid each cycle, req0 r1=0x11, req1 r2=0x22.
//     -> Grants alternate 0,1,0,1. write_enable3 pulses each cycle, one cycle after acceptance.
//  3. req1 writes r15=0x100.
//     -> Next cycle pc_write_enable=1, pc_write_data=0x100, write_enable3=0.
//  4. Stall held 3 cycles while out_valid=1 (r3=0xAB).
//     -> req_ready=0 and no strobes. fwd_addr=3 gives fwd_hit=1, fwd_data=0xAB.
//        Stall drops: a single commit of r3=0xAB.
//  5. Apply reset=0 for one cycle while out_valid=1 holds r4 (stall=0).
//     -> No write strobe in the reset cycle. Afterwards RegisterFile r4 is unchanged.
//  6. Only req1 valid for 4 cycles.
//     -> Accepted every cycle, rr_ptr stays at 0 after each grant, no idle bubbles.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared types and constants for the register-file writeback path.
// Pure declarations: no logic, no latency, no flow control.
package regfile_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 4;
    localparam logic [3:0] REG_PC = 4'hF;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    // Index that follows idx in a ring of n slots.
    function automatic int next_idx(input int idx, input int n);
        return (idx >= n - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Round-robin picker: first set request at or after ptr, scanning upward with wrap.
// Purely combinational, zero latency; no backpressure of its own.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic          any
);

    logic [IW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        cand      = '0;
        for (int k = 0; k < N; k++) begin
            cand = IW'((int'(ptr) + k) % N);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                grant_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file write port among NUM_REQ writeback sources; r15 goes to a PC strobe.
// One cycle accept-to-commit; a stalled full stage deasserts every req_ready.
module regfile_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int DATA_W  = regfile_pkg::DATA_W,
    parameter int ADDR_W  = regfile_pkg::ADDR_W
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic                        stall,
    output logic                        write_enable3,
    output logic [ADDR_W-1:0]           write_reg_addr3,
    output logic [DATA_W-1:0]           write_data3,
    output logic                        pc_write_enable,
    output logic [DATA_W-1:0]           pc_write_data,
    input  logic [ADDR_W-1:0]           fwd_addr,
    output logic                        fwd_hit,
    output logic [DATA_W-1:0]           fwd_data
);
    import regfile_pkg::*;

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } stage_t;

    logic                out_valid;
    stage_t              out_stage;
    logic [IW-1:0]       rr_ptr;

    logic [NUM_REQ-1:0]  grant;
    logic [IW-1:0]       grant_idx;
    logic                grant_any;
    logic                can_load;
    logic                xfer;
    logic                commit;
    logic                is_pc;
    stage_t              cand [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign cand[g].addr = req_addr[g*ADDR_W +: ADDR_W];
        assign cand[g].data = req_data[g*DATA_W +: DATA_W];
    end

    rr_arbiter #(
        .N  (NUM_REQ),
        .IW (IW)
    ) u_rr (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any       (grant_any)
    );

    // An empty stage may load even while stalled; a full one only when it drains.
    assign can_load  = !out_valid || !stall;
    assign req_ready = grant & {NUM_REQ{can_load && reset}};
    assign xfer      = grant_any && can_load && reset;

    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_stage <= '0;
            rr_ptr    <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_stage <= cand[grant_idx];
            rr_ptr    <= IW'(next_idx(int'(grant_idx), NUM_REQ));
        end else if (!stall) begin
            out_valid <= 1'b0;
        end
    end

    // Gating with reset keeps a write pending at reset time from reaching the register file.
    assign commit          = out_valid && !stall && reset;
    assign is_pc           = (out_stage.addr == ADDR_W'(REG_PC));
    assign write_enable3   = commit && !is_pc;
    assign pc_write_enable = commit && is_pc;
    assign write_reg_addr3 = out_stage.addr;
    assign write_data3     = out_stage.data;
    assign pc_write_data   = out_stage.data;

    assign fwd_hit  = out_valid && reset && (out_stage.addr == fwd_addr);
    assign fwd_data = fwd_hit ? out_stage.data : '0;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [7:0]  req_addr;
    logic [63:0] req_data;
    logic [1:0]  req_ready;
    logic        stall;
    logic        write_enable3;
    logic [3:0]  write_reg_addr3;
    logic [31:0] write_data3;
    logic        pc_write_enable;
    logic [31:0] pc_write_data;
    logic [3:0]  fwd_addr;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    typedef struct {
        bit          pc;
        logic [3:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    regfile_wb_arbiter #(.NUM_REQ(2), .DATA_W(32), .ADDR_W(4)) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_addr        (req_addr),
        .req_data        (req_data),
        .req_ready       (req_ready),
        .stall           (stall),
        .write_enable3   (write_enable3),
        .write_reg_addr3 (write_reg_addr3),
        .write_data3     (write_data3),
        .pc_write_enable (pc_write_enable),
        .pc_write_data   (pc_write_data),
        .fwd_addr        (fwd_addr),
        .fwd_hit         (fwd_hit),
        .fwd_data        (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [3:0] a0, input logic [31:0] d0,
                         input logic [3:0] a1, input logic [31:0] d1);
        req_valid = v;
        req_addr  = {a1, a0};
        req_data  = {d1, d0};
    endtask

    task automatic expect_wr(input bit pc, input logic [3:0] a, input logic [31:0] d);
        exp_t e;
        e.pc = pc; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every strobe must match the oldest outstanding accepted write.
    always @(negedge clk) begin
        if (write_enable3 || pc_write_enable) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {write_enable3, pc_write_enable, write_reg_addr3}, 64'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_strobes", {62'h0, pc_write_enable, write_enable3}, {62'h0, e.pc, !e.pc});
                chk("wr_addr", {60'h0, write_reg_addr3}, {60'h0, e.addr});
                chk("wr_data", {32'h0, e.pc ? pc_write_data : write_data3}, {32'h0, e.data});
            end
        end
    end

    initial begin
        reset = 1'b0; stall = 1'b0; fwd_addr = 4'd0;
        drive(2'b11, 4'd1, 32'h11, 4'd2, 32'h22);

        // Reset held two cycles with both requesters valid
        step(); step(); #2;
        chk("rst_ready", req_ready, 2'b00);
        chk("rst_we", write_enable3, 0);
        chk("rst_pcwe", pc_write_enable, 0);
        chk("rst_fwd_hit", fwd_hit, 0);
        chk("rst_fwd_data", fwd_data, 0);
        chk("rst_waddr", write_reg_addr3, 0);

        // Alternating grants 0,1,0,1
        reset = 1'b1; #2;
        chk("rr_g0", req_ready, 2'b01);
        chk("rr_idle_we", write_enable3, 0);
        expect_wr(0, 4'd1, 32'h11);
        for (int k = 1; k < 4; k++) begin
            step(); #2;
            chk("rr_alt", req_ready, (k % 2 == 1) ? 2'b10 : 2'b01);
            chk("rr_we_pulse", write_enable3, 1);
            if (k % 2 == 1) expect_wr(0, 4'd2, 32'h22);
            else            expect_wr(0, 4'd1, 32'h11);
        end

        // r15 goes to the PC strobe
        step(); drive(2'b10, 4'd0, 32'h0, 4'hF, 32'h100); #2;
        chk("pc_ready", req_ready, 2'b10);
        expect_wr(1, 4'hF, 32'h100);
        step(); drive(2'b00, 4'd0, 32'h0, 4'd0, 32'h0); #2;
        chk("pc_pcwe", pc_write_enable, 1);
        chk("pc_we", write_enable3, 0);
        chk("pc_data", pc_write_data, 32'h100);

        // Stall with a full stage
        step(); drive(2'b01, 4'd3, 32'hAB, 4'd0, 32'h0); #2;
        chk("st_load", req_ready, 2'b01);
        expect_wr(0, 4'd3, 32'hAB);
        for (int k = 0; k < 3; k++) begin
            step(); drive(2'b10, 4'd0, 32'h0, 4'd5, 32'h55); stall = 1'b1; fwd_addr = 4'd3; #2;
            chk("st_ready", req_ready, 2'b00);
            chk("st_we", {write_enable3, pc_write_enable}, 2'b00);
            chk("st_fwd_hit", fwd_hit, 1);
            chk("st_fwd_data", fwd_data, 32'hAB);
        end
        step(); stall = 1'b0; #2;
        chk("st_release_ready", req_ready, 2'b10);
        chk("st_release_we", write_enable3, 1);
        chk("st_release_fwd", fwd_hit, 1);
        expect_wr(0, 4'd5, 32'h55);
        step(); drive(2'b00, 4'd0, 32'h0, 4'd0, 32'h0); fwd_addr = 4'd5; #2;
        chk("fwd5_hit", fwd_hit, 1);
        chk("fwd5_data", fwd_data, 32'h55);

        // Stall on an empty stage still accepts
        step(); stall = 1'b1; fwd_addr = 4'd7; drive(2'b01, 4'd6, 32'h66, 4'd0, 32'h0); #2;
        chk("miss_hit", fwd_hit, 0);
        chk("miss_data", fwd_data, 0);
        chk("es_ready", req_ready, 2'b01);
        chk("es_we", write_enable3, 0);
        expect_wr(0, 4'd6, 32'h66);
        step(); drive(2'b00, 4'd0, 32'h0, 4'd0, 32'h0); fwd_addr = 4'd6; #2;
        chk("es_hold_we", write_enable3, 0);
        chk("es_hold_fwd", fwd_hit, 1);
        step(); stall = 1'b0; #2;
        chk("es_commit", write_enable3, 1);

        // Idle cycle keeps rr_ptr at 1
        step(); #2;
        chk("idle_we", write_enable3, 0);
        step(); drive(2'b11, 4'd8, 32'h88, 4'd9, 32'h99); #2;
        chk("idle_keeps_ptr", req_ready, 2'b10);
        expect_wr(0, 4'd9, 32'h99);

        // Reset discards a pending write to r4
        step(); drive(2'b10, 4'd0, 32'h0, 4'd4, 32'h44); #2;
        chk("r4_ready", req_ready, 2'b10);
        step(); reset = 1'b0; drive(2'b00, 4'd0, 32'h0, 4'd0, 32'h0); #2;
        chk("rst_pend_we", {write_enable3, pc_write_enable}, 2'b00);
        chk("rst_pend_ready", req_ready, 2'b00);
        step(); reset = 1'b1; #2;
        chk("rst_after_we", write_enable3, 0);

        // Only req1 valid: accepted back-to-back
        for (int k = 0; k < 4; k++) begin
            step(); drive(2'b10, 4'd0, 32'h0, 4'(10 + k), 32'hA0 + 32'(k)); #2;
            chk("solo_ready", req_ready, 2'b10);
            if (k > 0) chk("solo_we", write_enable3, 1);
            expect_wr(0, 4'(10 + k), 32'hA0 + 32'(k));
        end
        step(); drive(2'b00, 4'd0, 32'h0, 4'd0, 32'h0);
        step(); step(); step();
        chk("queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
